// File: rtl/reduce_clause_scheduler_pkg.sv
// Shared FSM encoding, signed bound limits and saturating negate for the
// reduce-clause scheduler. Widths default from the integer-variable macros.
`ifndef NUMBER_OF_INTEGER_VARIABLES
`define NUMBER_OF_INTEGER_VARIABLES 2
`endif
`ifndef BIT_WIDTH_OF_INTEGER_VARIABLE
`define BIT_WIDTH_OF_INTEGER_VARIABLE 8
`endif
`ifndef BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX
`define BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX 1
`endif

package reduce_clause_scheduler_pkg;

  localparam int VAR_W_P = `BIT_WIDTH_OF_INTEGER_VARIABLE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } sched_state_t;

  localparam logic signed [VAR_W_P-1:0] VAR_MAX = {1'b0, {(VAR_W_P-1){1'b1}}};
  localparam logic signed [VAR_W_P-1:0] VAR_MIN = {1'b1, {(VAR_W_P-1){1'b0}}};

  // Negating the most negative value would wrap back onto itself.
  function automatic logic signed [VAR_W_P-1:0] sat_negate(input logic signed [VAR_W_P-1:0] value);
    logic signed [VAR_W_P-1:0] result;
    if (value == VAR_MIN) begin
      result = VAR_MAX;
    end else begin
      result = -value;
    end
    return result;
  endfunction

endpackage

// File: rtl/reduce_clause_scheduler_reduce_clause.sv
// ReduceClause: isolates one variable of a linear clause a_i*x_i <= rest,
// rest = sum_{j!=i} a_j*y_j + a_N, giving bias = rest/|a_i| (truncating).

module reduce_clause_scheduler_reduce_clause #(
  parameter int NUM_VARS  = 2,
  parameter int VAR_W     = 8,
  parameter int VAR_IDX_W = 1
) (
  input  logic                          enable,
  input  logic                          reset,
  input  logic [VAR_IDX_W-1:0]          variable_index,
  input  logic [NUM_VARS*VAR_W-1:0]     assignment,
  input  logic [(NUM_VARS+1)*VAR_W-1:0] coefficients,
  output logic                          out_active,
  output logic                          out_sign,
  output logic [VAR_W-1:0]              out_bias
);

  localparam int ACC_W = 2 * VAR_W + $clog2(NUM_VARS + 1) + 1;

  logic signed [ACC_W-1:0] rest_s;
  logic signed [ACC_W-1:0] coef_i_s;
  logic signed [ACC_W-1:0] coef_j_s;
  logic signed [ACC_W-1:0] val_j_s;
  logic signed [ACC_W-1:0] divisor_s;

  // Accumulate the fixed part of the clause and pick out the selected coefficient.
  always_comb begin
    rest_s   = ACC_W'($signed(coefficients[NUM_VARS*VAR_W +: VAR_W]));
    coef_i_s = '0;
    coef_j_s = '0;
    val_j_s  = '0;
    for (int j = 0; j < NUM_VARS; j++) begin
      coef_j_s = ACC_W'($signed(coefficients[j*VAR_W +: VAR_W]));
      val_j_s  = ACC_W'($signed(assignment[j*VAR_W +: VAR_W]));
      if (variable_index == VAR_IDX_W'(j)) begin
        coef_i_s = coef_j_s;
      end else begin
        rest_s = rest_s + coef_j_s * val_j_s;
      end
    end
  end

  // Divide by the magnitude; a zero coefficient is steered to 1 and flagged inactive.
  always_comb begin
    divisor_s = '0;
    if (coef_i_s[ACC_W-1]) begin
      divisor_s = -coef_i_s;
    end else if (coef_i_s == '0) begin
      divisor_s[0] = 1'b1;
    end else begin
      divisor_s = coef_i_s;
    end
    out_bias   = VAR_W'(rest_s / divisor_s);
    out_sign   = ~coef_i_s[ACC_W-1];
    out_active = enable & ~reset & (coef_i_s != '0);
  end

endmodule

// File: rtl/reduce_clause_scheduler.sv
// Sweeps every clause through ReduceClause and folds the results into one
// [lower, upper] interval. Optional out_unsat via REDUCE_SCHED_UNSAT_DETECT_EN.

module reduce_clause_scheduler
  import reduce_clause_scheduler_pkg::*;
#(
  parameter int NUM_CLAUSES   = 4,
  parameter int CLAUSE_ADDR_W = 2,
  parameter int NUM_VARS      = `NUMBER_OF_INTEGER_VARIABLES,
  parameter int VAR_W         = `BIT_WIDTH_OF_INTEGER_VARIABLE,
  parameter int VAR_IDX_W     = `BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX
) (
  input  logic                          in_clk,
  input  logic                          in_reset,
  input  logic                          in_start,
  input  logic [VAR_IDX_W-1:0]          in_variable_index,
  input  logic [NUM_VARS*VAR_W-1:0]     in_current_assignment,
  output logic [CLAUSE_ADDR_W-1:0]      out_clause_address,
  output logic                          out_clause_read_enable,
  input  logic [(NUM_VARS+1)*VAR_W-1:0] in_clause_coefficients,
  output logic                          out_busy,
  output logic                          out_done,
  output logic [VAR_W-1:0]              out_upper_bound,
  output logic [VAR_W-1:0]              out_lower_bound,
  output logic                          out_has_upper,
  output logic                          out_has_lower
`ifdef REDUCE_SCHED_UNSAT_DETECT_EN
  ,
  output logic                          out_unsat
`endif
);

  localparam logic [CLAUSE_ADDR_W-1:0] LAST_ADDR = CLAUSE_ADDR_W'(NUM_CLAUSES - 1);

  sched_state_t               state_r, state_s;
  logic [VAR_IDX_W-1:0]       var_idx_r;
  logic [NUM_VARS*VAR_W-1:0]  assign_r;
  logic [CLAUSE_ADDR_W-1:0]   counter_r, counter_s;
  logic signed [VAR_W-1:0]    upper_r, upper_s, lower_r, lower_s;
  logic signed [VAR_W-1:0]    bias_s, cand_s;
  logic [VAR_W-1:0]           bias_raw_s;
  logic                       has_upper_r, has_upper_s, has_lower_r, has_lower_s;
  logic                       busy_r, done_r, rd_en_r;
  logic                       start_s, last_s, active_s, sign_s;

  assign start_s = in_start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign last_s  = (counter_r == LAST_ADDR);
  assign bias_s  = $signed(bias_raw_s);
  assign cand_s  = sat_negate(bias_s);

  reduce_clause_scheduler_reduce_clause #(
    .NUM_VARS  (NUM_VARS),
    .VAR_W     (VAR_W),
    .VAR_IDX_W (VAR_IDX_W)
  ) u_reduce_clause (
    .enable         (1'b1),
    .reset          (1'b0),
    .variable_index (var_idx_r),
    .assignment     (assign_r),
    .coefficients   (in_clause_coefficients),
    .out_active     (active_s),
    .out_sign       (sign_s),
    .out_bias       (bias_raw_s)
  );

  // Next-state and clause counter.
  always_comb begin
    state_s   = state_r;
    counter_s = counter_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          state_s   = ST_READ;
          counter_s = '0;
        end else begin
          state_s = state_r;
        end
      end
      ST_READ: state_s = ST_EVAL;
      ST_EVAL: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s   = ST_READ;
          counter_s = counter_r + CLAUSE_ADDR_W'(1'b1);
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Bound folding: a start re-opens the interval, each active clause narrows it.
  always_comb begin
    upper_s     = upper_r;
    lower_s     = lower_r;
    has_upper_s = has_upper_r;
    has_lower_s = has_lower_r;
    if (start_s) begin
      upper_s     = VAR_MAX;
      lower_s     = VAR_MIN;
      has_upper_s = 1'b0;
      has_lower_s = 1'b0;
    end else if ((state_r == ST_EVAL) && active_s) begin
      if (sign_s) begin
        upper_s     = (bias_s < upper_r) ? bias_s : upper_r;
        has_upper_s = 1'b1;
      end else begin
        lower_s     = (cand_s > lower_r) ? cand_s : lower_r;
        has_lower_s = 1'b1;
      end
    end else begin
      upper_s = upper_r;
    end
  end

  // State, operands, bounds and registered status outputs.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_r     <= ST_IDLE;
      var_idx_r   <= '0;
      assign_r    <= '0;
      counter_r   <= '0;
      upper_r     <= VAR_MAX;
      lower_r     <= VAR_MIN;
      has_upper_r <= 1'b0;
      has_lower_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_en_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start_s) begin
        var_idx_r <= in_variable_index;
        assign_r  <= in_current_assignment;
      end
      counter_r   <= counter_s;
      upper_r     <= upper_s;
      lower_r     <= lower_s;
      has_upper_r <= has_upper_s;
      has_lower_r <= has_lower_s;
      busy_r      <= (state_s == ST_READ) | (state_s == ST_EVAL);
      done_r      <= (state_s == ST_DONE);
      rd_en_r     <= (state_s == ST_READ);
    end
  end

  assign out_clause_address     = counter_r;
  assign out_clause_read_enable = rd_en_r;
  assign out_busy               = busy_r;
  assign out_done               = done_r;
  assign out_upper_bound        = upper_r;
  assign out_lower_bound        = lower_r;
  assign out_has_upper          = has_upper_r;
  assign out_has_lower          = has_lower_r;

`ifdef REDUCE_SCHED_UNSAT_DETECT_EN
  logic unsat_r;
  logic unsat_s;

  // Only a finished sweep may report an empty interval.
  always_comb begin
    if (state_s == ST_DONE) begin
      unsat_s = has_upper_s & has_lower_s & (lower_s > upper_s);
    end else begin
      unsat_s = 1'b0;
    end
  end

  // Registered unsat flag.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      unsat_r <= 1'b0;
    end else begin
      unsat_r <= unsat_s;
    end
  end

  assign out_unsat = unsat_r;
`endif

endmodule
